// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: condition codes, flag bit
// positions and the saturating-counter helpers used by the prediction table.
package branch_pkg;

  localparam int NVZ_W     = 3;
  localparam int CTR_MAX_W = 8;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_MI  = 3'b011;
  localparam logic [2:0] COND_PL  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_VS  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  // Counters are carried at CTR_MAX_W bits and narrowed by the caller, so one
  // helper serves every CTR_W the unit may be built with.
  function automatic logic [CTR_MAX_W-1:0] ctr_max(input int unsigned width);
    logic [CTR_MAX_W-1:0] all_ones;
    all_ones = '1;
    ctr_max  = all_ones >> (CTR_MAX_W - width);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic                 up,
                                                    input int unsigned          width);
    logic [CTR_MAX_W-1:0] top_v;
    top_v = ctr_max(width);
    if (up) begin
      ctr_next = (ctr == top_v) ? ctr : ctr + CTR_MAX_W'(1);
    end else begin
      ctr_next = (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    end
  endfunction

  // Weakly not-taken: one below the taken threshold.
  function automatic logic [CTR_MAX_W-1:0] ctr_reset(input int unsigned width);
    ctr_reset = ctr_max(width) >> 1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle of the fetch-lookup, decode-resolve, redirect and statistics signals
// between the pipeline (master) and the branch predict unit (slave).
interface branch_predict_unit_if
  import branch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int STAT_W = 16
);

  logic [NVZ_W-1:0]  flag_we;
  logic [NVZ_W-1:0]  flag_in;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic              id_valid;
  logic              id_stall;
  logic              id_branch;
  logic [2:0]        id_cond;
  logic [ADDR_W-1:0] id_pc;
  logic              id_pred_taken;
  logic [ADDR_W-1:0] id_target;
  logic [ADDR_W-1:0] id_pc_plus;
  logic              do_branch;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [NVZ_W-1:0]  flags;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output flag_we, flag_in, if_pc, id_valid, id_stall, id_branch, id_cond,
           id_pc, id_pred_taken, id_target, id_pc_plus,
    input  if_pred_taken, do_branch, redirect_valid, redirect_pc, flags,
           stat_branches, stat_mispred
  );

  modport slave (
    input  flag_we, flag_in, if_pc, id_valid, id_stall, id_branch, id_cond,
           id_pc, id_pred_taken, id_target, id_pc_plus,
    output if_pred_taken, do_branch, redirect_valid, redirect_pc, flags,
           stat_branches, stat_mispred
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 3-bit condition code against an {N,V,Z} flag set.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0]       cond,
  input  logic [NVZ_W-1:0] nvz,
  output logic             taken
);

  logic n, v, z;

  assign n = nvz[FLAG_N];
  assign v = nvz[FLAG_V];
  assign z = nvz[FLAG_Z];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:  taken = ~z;
      COND_EQ:  taken = z;
      COND_GT:  taken = ~n & ~z;
      COND_MI:  taken = n;
      COND_PL:  taken = ~n | z;
      COND_LE:  taken = n | z;
      COND_VS:  taken = v;
      COND_UNC: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver: architectural NVZ flags, condition evaluation, a table of
// saturating-counter predictors, registered mispredict redirects and statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BHT_DEPTH   = 16,
  parameter int CTR_W       = 2,
  parameter int FLAG_BYPASS = 1,
  parameter int STAT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset(CTR_W));

  logic [CTR_W-1:0]  bht [BHT_DEPTH];
  logic [NVZ_W-1:0]  flags_q;
  logic [NVZ_W-1:0]  eval_flags;
  logic              cond_true;
  logic              resolve;
  logic              taken;
  logic              mispredict;
  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  update_idx;
  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_mispred_q;
  logic              unused_pc_bits;

  // Instructions are halfword aligned, so pc[0] never selects an entry.
  assign lookup_idx = bus.if_pc[IDX_W:1];
  assign update_idx = bus.id_pc[IDX_W:1];
  assign unused_pc_bits = ^{bus.if_pc[0], bus.id_pc[0],
                            bus.if_pc[ADDR_W-1:IDX_W+1], bus.id_pc[ADDR_W-1:IDX_W+1]};

  always_comb begin
    eval_flags = flags_q;
    if (FLAG_BYPASS != 0) begin
      eval_flags = (bus.flag_we & bus.flag_in) | (~bus.flag_we & flags_q);
    end
  end

  branch_cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .nvz   (eval_flags),
    .taken (cond_true)
  );

  assign resolve    = bus.id_valid & bus.id_branch & ~bus.id_stall;
  assign taken      = resolve & cond_true;
  assign mispredict = resolve & (taken != bus.id_pred_taken);

  assign bus.if_pred_taken  = bht[lookup_idx][CTR_W-1];
  assign bus.do_branch      = taken;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flags          = flags_q;
  assign bus.stat_branches  = stat_branches_q;
  assign bus.stat_mispred   = stat_mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      for (int i = 0; i < NVZ_W; i++) begin
        if (bus.flag_we[i]) flags_q[i] <= bus.flag_in[i];
      end
    end
  end

  // A lookup of the entry being trained this cycle sees the old value, since
  // the write lands on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CTR_RST;
      end
    end else if (resolve) begin
      bht[update_idx] <= CTR_W'(ctr_next(CTR_MAX_W'(bht[update_idx]), taken, CTR_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= taken ? bus.id_target : bus.id_pc_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (resolve && (stat_branches_q != '1)) begin
        stat_branches_q <= stat_branches_q + STAT_W'(1);
      end
      if (mispredict && (stat_mispred_q != '1)) begin
        stat_mispred_q <= stat_mispred_q + STAT_W'(1);
      end
    end
  end

endmodule
